// File: rtl/rvfpm_pkg.sv
// Shared RV32F issue definitions: opcode/funct7 constants, decoded head
// instruction record and the decode helper used by the issue stage.
package rvfpm_pkg;

  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;

  localparam logic [6:0] F7_FADD   = 7'b0000000;
  localparam logic [6:0] F7_FSUB   = 7'b0000100;
  localparam logic [6:0] F7_FMUL   = 7'b0001000;
  localparam logic [6:0] F7_FDIV   = 7'b0001100;
  localparam logic [6:0] F7_FSGNJ  = 7'b0010000;
  localparam logic [6:0] F7_FMINMX = 7'b0010100;
  localparam logic [6:0] F7_FCMP   = 7'b1010000;
  localparam logic [6:0] F7_FMVXW  = 7'b1110000;
  localparam logic [6:0] F7_FCVTWS = 7'b1100000;
  localparam logic [6:0] F7_FMVWX  = 7'b1111000;
  localparam logic [6:0] F7_FCVTSW = 7'b1101000;

  typedef struct packed {
    logic       legal;
    logic       writesF;
    logic       usesRs1;
    logic       usesRs2;
    logic       usesRs3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
  } fp_decoded_t;

  // Integer-destination ops (compare, FMV.X.W, FCVT.W.S) do not write the FP
  // file; integer-source ops (FMV.W.X, FCVT.S.W) do not read FP rs1.
  function automatic fp_decoded_t rvfpm_decode(input logic [31:0] instr);
    fp_decoded_t d;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic        is_fp;
    logic        is_r4;
    op    = instr[6:0];
    f7    = instr[31:25];
    is_fp = (op == OP_FP);
    is_r4 = (op == OP_FMADD) || (op == OP_FMSUB) || (op == OP_FNMSUB) || (op == OP_FNMADD);
    d.legal   = is_fp || is_r4;
    d.writesF = is_r4 || (is_fp && !(f7 == F7_FMVXW || f7 == F7_FCMP || f7 == F7_FCVTWS));
    d.usesRs1 = is_r4 || (is_fp && !(f7 == F7_FMVWX || f7 == F7_FCVTSW));
    d.usesRs2 = is_r4 || (is_fp && (f7 == F7_FADD || f7 == F7_FSUB || f7 == F7_FMUL ||
                                    f7 == F7_FDIV || f7 == F7_FSGNJ || f7 == F7_FMINMX ||
                                    f7 == F7_FCMP));
    d.usesRs3 = is_r4;
    d.rd      = instr[11:7];
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.rs3     = instr[31:27];
    return d;
  endfunction

endpackage

// File: rtl/rvfpm_issue_fifo.sv
// Instruction queue for the FP issue stage: circular buffer with occupancy
// count, flush, and push refused while full even if a pop happens that edge.
module rvfpm_issue_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (cnt != '0) && !flush;
  assign rdata   = mem[rd_ptr];
  assign level   = cnt;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rvfpm_issue.sv
// In-order RV32F issue stage: queues instructions, decodes the head, holds it
// on a register hazard from the per-register countdown scoreboard, and drops
// non-F opcodes with an illegal pulse.
module rvfpm_issue
  import rvfpm_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int PIPELINE_STAGES = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instruction,
  input  logic [31:0]                  in_data_fromXReg,
  input  logic                         flush,
  input  logic                         stall,
  output logic                         enable,
  output logic [31:0]                  instruction,
  output logic [31:0]                  data_fromXReg,
  output logic                         illegal,
  output logic [$clog2(FIFO_DEPTH):0]  level
);
  localparam int CW = $clog2(PIPELINE_STAGES + 1) + 1;
  localparam int RW = $clog2(NUM_REGS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [63:0]          head;
  logic [31:0]          head_instr;
  logic [31:0]          head_data;
  fp_decoded_t          dec;
  logic [CW-1:0]        cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic                 not_empty;
  logic                 hazard;
  logic                 do_issue;
  logic                 do_drop;
  logic                 push;

  assign in_ready   = (level != LW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready && !flush;
  assign head_instr = head[63:32];
  assign head_data  = head[31:0];
  assign dec        = rvfpm_decode(head_instr);
  assign not_empty  = (level != '0);

  rvfpm_issue_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata ({in_instruction, in_data_fromXReg}),
    .pop   (do_issue || do_drop),
    .rdata (head),
    .level (level)
  );

  // Hazard sees scoreboard values from before this edge's update.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
    hazard = (dec.usesRs1 && busy[dec.rs1[RW-1:0]]) ||
             (dec.usesRs2 && busy[dec.rs2[RW-1:0]]) ||
             (dec.usesRs3 && busy[dec.rs3[RW-1:0]]);
    do_issue = not_empty && dec.legal && !hazard && !stall && !flush;
    do_drop  = not_empty && !dec.legal && !flush;
  end

  // Scoreboard countdown; a new issue to rd overrides that register's decrement.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (do_issue && dec.writesF && (dec.rd[RW-1:0] == RW'(r)))
          cnt[r] <= CW'(PIPELINE_STAGES);
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // Registered issue outputs: single-cycle pulses, payload zero when idle.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      enable        <= 1'b0;
      instruction   <= '0;
      data_fromXReg <= '0;
      illegal       <= 1'b0;
    end else begin
      enable        <= do_issue;
      instruction   <= do_issue ? head_instr : '0;
      data_fromXReg <= do_issue ? head_data : '0;
      illegal       <= do_drop;
    end
  end

endmodule

// File: tb/tb_rvfpm_issue.sv
// Randomised and directed bench for rvfpm_issue with a timestamp-based
// reference model and an event scoreboard checked by a separate monitor.
module tb_rvfpm_issue;
  localparam int PS = 2;
  localparam int D  = 4;
  localparam int NR = 32;

  logic        ck = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_data_fromXReg;
  logic        flush;
  logic        stall;
  logic        enable;
  logic [31:0] instruction;
  logic [31:0] data_fromXReg;
  logic        illegal;
  logic [2:0]  level;

  rvfpm_issue #(
    .NUM_REGS        (NR),
    .PIPELINE_STAGES (PS),
    .FIFO_DEPTH      (D)
  ) dut (
    .ck               (ck),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instruction   (in_instruction),
    .in_data_fromXReg (in_data_fromXReg),
    .flush            (flush),
    .stall            (stall),
    .enable           (enable),
    .instruction      (instruction),
    .data_fromXReg    (data_fromXReg),
    .illegal          (illegal),
    .level            (level)
  );

  always #5 ck = ~ck;

  typedef struct { bit ill; logic [31:0] ins; logic [31:0] dat; int edge_n; } ev_t;
  typedef struct { logic [31:0] ins; logic [31:0] dat; } ent_t;

  ev_t  expq[$];
  ent_t mq[$];
  int   free_at[NR];
  int   n_edge    = 0;
  int   exp_level = 0;
  int   checks    = 0;
  int   passed    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n_edge - 1);
  endtask

  // Reference classification taken straight from the opcode/funct7 rules.
  function automatic void m_dec(input logic [31:0] ins, output bit legal, output bit wr,
                                output bit r1, output bit r2, output bit r3);
    logic [6:0] op;
    logic [6:0] f7;
    bit fp;
    bit r4;
    op = ins[6:0];
    f7 = ins[31:25];
    fp = (op == 7'b1010011);
    r4 = op inside {7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
    legal = fp || r4;
    wr = r4 || (fp && !(f7 inside {7'b1110000, 7'b1010000, 7'b1100000}));
    r1 = r4 || (fp && !(f7 inside {7'b1111000, 7'b1101000}));
    r2 = r4 || (fp && (f7 inside {7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100,
                                  7'b0010000, 7'b0010100, 7'b1010000}));
    r3 = r4;
  endfunction

  // Register r is readable at edge n once n >= free_at[r] (producer edge + PS + 1).
  task automatic model_edge();
    bit   room;
    bit   lg, wr, r1, r2, r3, haz;
    ent_t h;
    ev_t  e;
    if (rst) begin
      mq.delete();
      foreach (free_at[i]) free_at[i] = 0;
    end else begin
      room = (mq.size() != D);
      if (flush) mq.delete();
      else begin
        if (mq.size() > 0) begin
          h = mq[0];
          m_dec(h.ins, lg, wr, r1, r2, r3);
          haz = (r1 && n_edge < free_at[h.ins[19:15]]) ||
                (r2 && n_edge < free_at[h.ins[24:20]]) ||
                (r3 && n_edge < free_at[h.ins[31:27]]);
          if (!lg) begin
            void'(mq.pop_front());
            e.ill = 1; e.ins = h.ins; e.dat = h.dat; e.edge_n = n_edge;
            expq.push_back(e);
          end else if (!stall && !haz) begin
            void'(mq.pop_front());
            e.ill = 0; e.ins = h.ins; e.dat = h.dat; e.edge_n = n_edge;
            expq.push_back(e);
            if (wr) free_at[h.ins[11:7]] = n_edge + PS + 1;
          end
        end
        if (in_valid && room) begin
          h.ins = in_instruction; h.dat = in_data_fromXReg;
          mq.push_back(h);
        end
      end
    end
    exp_level = mq.size();
    n_edge++;
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] dat,
                      input bit fl = 0, input bit st = 0);
    in_valid = v; in_instruction = ins; in_data_fromXReg = dat; flush = fl; stall = st;
    @(posedge ck);
    model_edge();
    @(negedge ck);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] f7s [12] = '{7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100, 7'b0010000,
                            7'b0010100, 7'b1010000, 7'b1110000, 7'b1100000, 7'b1111000,
                            7'b1101000, 7'b0101100};
    logic [6:0] r4s  [4] = '{7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
    logic [6:0] bad  [3] = '{7'b0010011, 7'b0000111, 7'b0100111};
    logic [4:0] rd, rs1, rs2, rs3;
    logic [2:0] f3;
    rd  = 5'($urandom_range(3)); rs1 = 5'($urandom_range(3));
    rs2 = 5'($urandom_range(3)); rs3 = 5'($urandom_range(3));
    f3  = 3'($urandom_range(7));
    case ($urandom_range(5))
      0, 1, 2: return {f7s[$urandom_range(11)], rs2, rs1, f3, rd, 7'b1010011};
      3:       return {rs3, 2'b00, rs2, rs1, f3, rd, r4s[$urandom_range(3)]};
      4:       return {7'($urandom), rs2, rs1, f3, rd, bad[$urandom_range(2)]};
      default: return {7'b0101100, 5'd0, rs1, f3, rd, 7'b1010011};
    endcase
  endfunction

  // Monitor: compares every presented output against the scoreboard queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge ck);
      chk("level", 64'(level), 64'(exp_level));
      chk("in_ready", 64'(in_ready), 64'(exp_level != D));
      chk("en_ill_excl", 64'(enable & illegal), 64'd0);
      if (!enable) chk("idle_zero", {instruction, data_fromXReg}, 64'd0);
      while (expq.size() > 0 && expq[0].edge_n < n_edge - 1) begin
        e = expq.pop_front();
        checks++;
        $display("FAIL missing_out: nothing seen, expected ins %h ill %0d at edge %0d",
                 e.ins, e.ill, e.edge_n);
      end
      if (enable || illegal) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got en %0d ill %0d ins %h, expected none",
                   enable, illegal, instruction);
        end else begin
          e = expq.pop_front();
          chk("out_kind", {62'd0, illegal, enable}, {62'd0, e.ill, !e.ill});
          chk("out_ins", 64'(instruction), e.ill ? 64'd0 : 64'(e.ins));
          chk("out_dat", 64'(data_fromXReg), e.ill ? 64'd0 : 64'(e.dat));
          chk("out_edge", 64'(n_edge - 1), 64'(e.edge_n));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_instruction = 0; in_data_fromXReg = 0; flush = 0; stall = 0;
    idle(3);
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    idle(2);

    // Single FADD into empty queue.
    step(1, 32'h002081D3, 32'h1234);
    idle(5);
    // Back-to-back dependent FMUL.
    step(1, 32'h002081D3, 32'h1);
    step(1, 32'h10118253, 32'h2);
    idle(7);
    // FMV.X.W hazard, followed by independent FADD.
    step(1, 32'h002081D3, 32'h3);
    step(1, 32'hE00182D3, 32'h4);
    step(1, 32'h002081D3, 32'h5);
    idle(8);
    // Stall with 5 offered: queue fills at 4.
    for (int i = 0; i < 5; i++) step(1, 32'h00000053 | (32'(i) << 7), 32'(i + 100), 0, 1);
    chk("full_level", 64'(level), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    idle(6);
    // Non-F opcode is dropped.
    step(1, 32'h00000013, 32'h77);
    idle(3);
    // Flush at level 3.
    for (int i = 0; i < 3; i++) step(1, 32'h002081D3, 32'(i), 0, 1);
    chk("pre_flush_level", 64'(level), 64'd3);
    step(1, 32'h002081D3, 32'h9, 1, 0);
    chk("flush_level", 64'(level), 64'd0);
    idle(2);
    // Reset while FMUL waits on FADD.
    step(1, 32'h002081D3, 32'hA);
    step(1, 32'h10118253, 32'hB);
    step(0, 32'h0, 32'h0);
    rst = 1'b1;
    step(0, 32'h0, 32'h0);
    chk("rst_mid_level", 64'(level), 64'd0);
    chk("rst_mid_enable", 64'(enable), 64'd0);
    rst = 1'b0;
    idle(1);
    step(1, 32'h002081D3, 32'hC);
    step(1, 32'h10118253, 32'hD);
    idle(7);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      step($urandom_range(3) != 0, gen_instr(), $urandom,
           $urandom_range(39) == 0, $urandom_range(7) == 0);
    end

    for (int i = 0; i < 60 && mq.size() != 0; i++) idle(1);
    idle(6);
    chk("drain_empty", 64'(mq.size() + expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
